// File: rtl/led_pattern_gen_if.sv
// Configuration and LED-drive bundle for led_pattern_gen.
// The bench or host side uses the master modport; the generator uses the slave modport.
interface led_pattern_gen_if #(
  parameter int CHANNELS  = 4,
  parameter int PWM_BITS  = 8,
  parameter int RATE_BITS = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [1:0]           cfg_mode;
  logic [PWM_BITS-1:0]  cfg_duty;
  logic [RATE_BITS-1:0] cfg_rate;
  logic [CHANNELS-1:0]  led;
  logic                 frame_tick;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
    input  led, frame_tick
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
    output led, frame_tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared PWM timebase drives per-channel
// OFF / DIM / BLINK / BREATHE patterns, each configured by single-cycle writes.
module led_pattern_gen #(
  parameter int CHANNELS  = 4,
  parameter int PWM_BITS  = 8,
  parameter int RATE_BITS = 8,
  parameter int PRESCALE  = 64
) (
  input logic              clk,
  input logic              rst,
  led_pattern_gen_if.slave bus
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_DIM     = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                frame_tick_q, frame_tick_d;
  logic [CHANNELS-1:0] led_q, led_d;

  logic [CHANNELS-1:0][1:0]           mode_q, mode_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_q, duty_d;
  logic [CHANNELS-1:0][RATE_BITS-1:0] rate_q, rate_d;
  logic [CHANNELS-1:0][RATE_BITS-1:0] fcnt_q, fcnt_d;
  logic [CHANNELS-1:0]                blink_q, blink_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  level_q, level_d;
  logic [CHANNELS-1:0]                dir_up_q, dir_up_d;

  logic step;
  logic wrap;
  logic wr_en;

  assign step  = (presc_q == PS_LAST);
  // The frame event fires on the same edge that returns pwm_cnt to 0, so a new
  // brightness level always lines up with the start of a PWM frame.
  assign wrap  = step && (pwm_cnt_q == PWM_MAX);
  assign wr_en = bus.cfg_we && (int'(bus.cfg_ch) < CHANNELS);

  always_comb begin
    presc_d      = step ? '0 : presc_q + 1'b1;
    pwm_cnt_d    = step ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    frame_tick_d = wrap;
  end

  always_comb begin
    mode_d   = mode_q;
    duty_d   = duty_q;
    rate_d   = rate_q;
    fcnt_d   = fcnt_q;
    blink_d  = blink_q;
    level_d  = level_q;
    dir_up_d = dir_up_q;
    led_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_q[i])
        MODE_OFF:     led_d[i] = 1'b0;
        MODE_DIM:     led_d[i] = (pwm_cnt_q < duty_q[i]);
        MODE_BLINK:   led_d[i] = blink_q[i];
        MODE_BREATHE: led_d[i] = (pwm_cnt_q < level_q[i]);
        default:      led_d[i] = 1'b0;
      endcase

      // A write to this channel wins over a simultaneous frame event.
      if (wr_en && (int'(bus.cfg_ch) == i)) begin
        mode_d[i]   = bus.cfg_mode;
        duty_d[i]   = bus.cfg_duty;
        rate_d[i]   = bus.cfg_rate;
        fcnt_d[i]   = '0;
        blink_d[i]  = 1'b0;
        level_d[i]  = '0;
        dir_up_d[i] = 1'b1;
      end else if (wrap && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BREATHE)) begin
        if (fcnt_q[i] == rate_q[i]) begin
          fcnt_d[i] = '0;
          if (mode_q[i] == MODE_BLINK) begin
            blink_d[i] = ~blink_q[i];
          end else if (dir_up_q[i]) begin
            level_d[i] = level_q[i] + 1'b1;
            if (level_q[i] == PWM_MAX - 1'b1) dir_up_d[i] = 1'b0;
          end else begin
            level_d[i] = level_q[i] - 1'b1;
            if (level_q[i] == PWM_ONE) dir_up_d[i] = 1'b1;
          end
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      pwm_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
      led_q        <= '0;
      mode_q       <= '0;
      duty_q       <= '0;
      rate_q       <= '0;
      fcnt_q       <= '0;
      blink_q      <= '0;
      level_q      <= '0;
      dir_up_q     <= '1;
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      frame_tick_q <= frame_tick_d;
      led_q        <= led_d;
      mode_q       <= mode_d;
      duty_q       <= duty_d;
      rate_q       <= rate_d;
      fcnt_q       <= fcnt_d;
      blink_q      <= blink_d;
      level_q      <= level_d;
      dir_up_q     <= dir_up_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 4-channel and a 3-channel instance with
// PWM_BITS=4, PRESCALE=2 (32-cycle frames), checked frame by frame against hand values.
module tb_led_pattern_gen;

  localparam int PWM_BITS  = 4;
  localparam int RATE_BITS = 8;
  localparam int PRESCALE  = 2;
  localparam int FRAME     = 32;

  localparam int M_OFF = 0, M_DIM = 1, M_BLINK = 2, M_BREATHE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_pattern_gen_if #(.CHANNELS(4), .PWM_BITS(PWM_BITS), .RATE_BITS(RATE_BITS)) bus4 ();
  led_pattern_gen_if #(.CHANNELS(3), .PWM_BITS(PWM_BITS), .RATE_BITS(RATE_BITS)) bus3 ();

  led_pattern_gen #(.CHANNELS(4), .PWM_BITS(PWM_BITS), .RATE_BITS(RATE_BITS), .PRESCALE(PRESCALE))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));
  led_pattern_gen #(.CHANNELS(3), .PWM_BITS(PWM_BITS), .RATE_BITS(RATE_BITS), .PRESCALE(PRESCALE))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    int ch;
    int mode;
    int duty;
    int rate;
    int exp_on;
  } vec_t;

  vec_t vecs [10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wr4(input int ch, input int mode, input int duty, input int rate);
    bus4.cfg_ch   = 2'(ch);
    bus4.cfg_mode = 2'(mode);
    bus4.cfg_duty = 4'(duty);
    bus4.cfg_rate = 8'(rate);
    bus4.cfg_we   = 1'b1;
    @(negedge clk);
    bus4.cfg_we   = 1'b0;
  endtask

  task automatic wr3(input int ch, input int mode, input int duty, input int rate);
    bus3.cfg_ch   = 2'(ch);
    bus3.cfg_mode = 2'(mode);
    bus3.cfg_duty = 4'(duty);
    bus3.cfg_rate = 8'(rate);
    bus3.cfg_we   = 1'b1;
    @(negedge clk);
    bus3.cfg_we   = 1'b0;
  endtask

  // Advances to the next falling edge at which frame_tick is high (bounded).
  task automatic ticks_until(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus4.frame_tick && n < 100);
    if (!bus4.frame_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_tick_timeout: got no tick in %0d cycles, expected one within %0d", n, FRAME);
    end
  endtask

  task automatic sync_tick();
    int n;
    ticks_until(n);
  endtask

  // Counts over the 32 falling edges following a tick, i.e. exactly one frame.
  // sel: 0 dut4 led[ch], 1 dut3 led[ch], 2 any dut3 led, 3 any dut4 led, 4 dut4 frame_tick
  task automatic measure(input int sel, input int ch, output int cnt);
    cnt = 0;
    repeat (FRAME) begin
      @(negedge clk);
      case (sel)
        0:       cnt += int'(bus4.led[ch]);
        1:       cnt += int'(bus3.led[ch]);
        2:       cnt += int'(|bus3.led);
        3:       cnt += int'(|bus4.led);
        default: cnt += int'(bus4.frame_tick);
      endcase
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, cnt, m, lvl, run, best;

    vecs[0] = '{1, M_DIM,     4, 0,  8};
    vecs[1] = '{1, M_DIM,     0, 0,  0};
    vecs[2] = '{3, M_DIM,    15, 0, 30};
    vecs[3] = '{3, M_DIM,     1, 0,  2};
    vecs[4] = '{2, M_DIM,     8, 0, 16};
    vecs[5] = '{0, M_OFF,     9, 0,  0};
    vecs[6] = '{2, M_BLINK,   0, 0, 32};
    vecs[7] = '{1, M_BLINK,   0, 5,  0};
    vecs[8] = '{3, M_BREATHE, 0, 0,  2};
    vecs[9] = '{3, M_OFF,     0, 0,  0};

    bus4.cfg_we = 1'b0; bus4.cfg_ch = '0; bus4.cfg_mode = '0; bus4.cfg_duty = '0; bus4.cfg_rate = '0;
    bus3.cfg_we = 1'b0; bus3.cfg_ch = '0; bus3.cfg_mode = '0; bus3.cfg_duty = '0; bus3.cfg_rate = '0;

    // Reset state, checked before and after a clock edge while held.
    #1 rst = 1'b1;
    #2;
    check("reset_led", int'(bus4.led), 0);
    check("reset_tick", int'(bus4.frame_tick), 0);
    @(posedge clk);
    #1;
    check("reset_led_clocked", int'(bus4.led), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle run: first tick 32 cycles after release, one tick per frame, LEDs dark.
    ticks_until(n);
    check("first_tick_latency", n, FRAME);
    measure(3, 0, cnt);
    check("idle_led", cnt, 0);
    check("tick_at_frame_end", int'(bus4.frame_tick), 1);
    measure(4, 0, cnt);
    check("ticks_per_frame", cnt, 1);

    // Table: write at a tick, skip the partial frame, count on-cycles in the next full frame.
    for (int v = 0; v < 10; v++) begin
      wr4(vecs[v].ch, vecs[v].mode, vecs[v].duty, vecs[v].rate);
      sync_tick();
      measure(0, vecs[v].ch, cnt);
      check($sformatf("vec%0d_on_cycles", v), cnt, vecs[v].exp_on);
    end

    // BLINK rate=2 on ch0: low for frames 1-2, then toggles every 3 frames.
    wr4(0, M_BLINK, 0, 2);
    sync_tick();
    for (int k = 1; k <= 9; k++) begin
      measure(0, 0, cnt);
      check($sformatf("blink_frame%0d", k), cnt, ((k / 3) % 2) * FRAME);
    end

    // BREATHE rate=0 on ch2: level per frame follows a 30-frame triangle 0..15..0.
    wr4(2, M_BREATHE, 0, 0);
    sync_tick();
    for (int k = 1; k <= 32; k++) begin
      measure(0, 2, cnt);
      m   = k % 30;
      lvl = (m <= 15) ? m : 30 - m;
      check($sformatf("breathe_frame%0d", k), cnt, 2 * lvl);
    end

    // Write landing on the frame-wrap edge: the write wins, the blink toggle is lost.
    wr4(0, M_BLINK, 0, 0);
    sync_tick();
    repeat (FRAME) @(negedge clk);
    repeat (FRAME - 1) @(negedge clk);
    bus4.cfg_ch = 2'd0; bus4.cfg_mode = 2'(M_BLINK); bus4.cfg_duty = '0; bus4.cfg_rate = '0;
    bus4.cfg_we = 1'b1;
    @(negedge clk);
    bus4.cfg_we = 1'b0;
    check("coincident_tick", int'(bus4.frame_tick), 1);
    measure(0, 0, cnt);
    check("coincident_no_toggle", cnt, 0);
    measure(0, 0, cnt);
    check("coincident_next_toggle", cnt, FRAME);

    // 3-channel instance: out-of-range channel writes are ignored.
    wr3(3, M_DIM, 8, 0);
    sync_tick();
    measure(2, 0, cnt);
    check("ignored_ch3_led", cnt, 0);
    wr3(2, M_DIM, 8, 0);
    sync_tick();
    measure(1, 2, cnt);
    check("dut3_ch2_dim8", cnt, 16);
    wr3(3, M_OFF, 0, 0);
    sync_tick();
    measure(1, 2, cnt);
    check("ignored_ch3_keeps_ch2", cnt, 16);

    // Asynchronous reset mid-pattern, away from any clock edge.
    wr4(1, M_DIM, 15, 0);
    sync_tick();
    @(negedge clk);
    check("pre_reset_led1", int'(bus4.led[1]), 1);
    #2 rst = 1'b1;
    #1;
    check("reset_async_led", int'(bus4.led), 0);
    check("reset_async_tick", int'(bus4.frame_tick), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ticks_until(n);
    check("post_reset_tick_latency", n, FRAME);
    measure(3, 0, cnt);
    check("post_reset_dark_f1", cnt, 0);
    measure(3, 0, cnt);
    check("post_reset_dark_f2", cnt, 0);

    // Rewrite after reset: DIM duty=4 gives one run of 8 on-cycles per frame.
    wr4(1, M_DIM, 4, 0);
    sync_tick();
    cnt = 0; run = 0; best = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (bus4.led[1]) begin
        cnt++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    check("rewrite_dim4_on", cnt, 8);
    check("rewrite_dim4_run", best, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent LED channels (1..32).
REQ-002 Parameter PWM_BITS, default 8: PWM counter / duty / brightness width (2..16).
REQ-003 Parameter RATE_BITS, default 8: width of the per-channel rate field.
REQ-004 Parameter PRESCALE, default 64: CLOCK cycles per PWM step (>=1).
REQ-005 CLOCK  in  1  system clock, all logic on rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 cfg_we  in  1  single-cycle configuration write strobe.
REQ-008 cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(CHANNELS)).
REQ-009 cfg_mode  in  2  0=OFF, 1=DIM, 2=BLINK, 3=BREATHE.
REQ-010 cfg_duty  in  PWM_BITS  DIM duty value.
REQ-011 cfg_rate  in  RATE_BITS  BLINK/BREATHE rate; one event every cfg_rate+1 frames.
REQ-012 led  out  CHANNELS  registered LED drive, bit i = channel i.
REQ-013 frame_tick  out  1  one-cycle pulse at each PWM frame wrap.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1, wrap, and assert internal step on the cycle it equals PRESCALE-1; with PRESCALE=1, step is asserted every cycle.
REQ-015 Shared pwm_cnt (PWM_BITS) SHALL increment on step, wrapping from all-ones to 0.
REQ-016 frame_tick SHALL be registered, high for exactly one cycle, on the cycle after the step that wraps pwm_cnt to 0.
REQ-017 Frame period SHALL be PRESCALE * 2^PWM_BITS cycles.
REQ-018 Each channel SHALL hold mode, duty, rate, frame counter, blink state, level, direction.
REQ-019 Write: on cfg_we with cfg_ch < CHANNELS, the channel SHALL load mode/duty/rate and clear frame counter, blink state, level; set direction up; effective next cycle.
REQ-020 Write with cfg_ch >= CHANNELS SHALL be ignored, with no state change.
REQ-021 A write coinciding with a frame event on the same channel SHALL take priority; the frame event is dropped for that channel.
REQ-022 OFF: led[i]=0.
REQ-023 DIM: led[i] = (pwm_cnt < duty); duty=0 gives constant 0; duty all-ones gives (2^PWM_BITS-1)/2^PWM_BITS on-time.
REQ-024 BLINK: frame counter increments at each frame wrap; when it equals rate, blink state toggles and counter clears; led[i]=blink state.
REQ-025 BREATHE: same frame counter rule; at each event, level steps +1 (up) or -1 (down).
REQ-026 BREATHE direction SHALL reverse on reaching all-ones (up->down) or 0 (down->up), so the sequence is 0,1..max,max-1..0,1...
REQ-027 BREATHE output: led[i] = (pwm_cnt < level).
REQ-028 Changing mode via write SHALL restart the pattern from cleared state (REQ-019).
REQ-029 led SHALL be registered: one cycle of latency from the pwm_cnt/state values to the pin.
REQ-030 Frame counter SHALL not exceed rate; rate=0 means an event every frame.

Reset
REQ-031 While RESET is high: led=0, frame_tick=0, prescaler=0, pwm_cnt=0, all channels OFF with duty/rate/counters/level cleared, direction up.
REQ-032 Assertion SHALL take effect immediately (asynchronous); release is sampled on the next rising CLOCK; reset mid-pattern SHALL discard all configuration.

Verification (CHANNELS=4, PWM_BITS=4, PRESCALE=2 unless stated; frame = 32 cycles)
REQ-033 Release reset, no writes -> led=0 always; frame_tick pulses once every 32 cycles, first pulse 32 cycles after release.
REQ-034 Write ch1 DIM duty=4 -> led[1] high 8 consecutive cycles per 32-cycle frame; duty=0 -> led[1] stays 0.
REQ-035 Write ch0 BLINK rate=2 -> led[0] toggles every 3 frames (96 cycles), starting low after write.
REQ-036 Write ch2 BREATHE rate=0 -> level per frame 0,1..15,14..0; full triangle repeats every 30 frames; led[2] on-cycles per frame = 2*level.
REQ-037 CHANNELS=3, write cfg_ch=3 mode=DIM duty=8 -> no led change; write coincident with frame_tick on ch0 BLINK -> counter cleared, no toggle.
REQ-038 Assert RESET mid-BREATHE for 1 cycle -> led=0 at once; after release all channels OFF until rewritten.
